// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the MEM stage, the shared memory
// port and the hazard unit. The arbiter takes the slave view; the
// pipeline/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // Fetch side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_abort;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // Data side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // Memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_funct3;
  logic [DATA_W-1:0] m_rdata;
  // Hazard unit
  logic              if_stall;
  logic              mem_stall;

  modport slave (
    input  i_req, i_addr, i_abort, d_req, d_we, d_addr, d_wdata, d_funct3, m_rdata,
    output i_done, i_rdata, d_done, d_rdata, m_en, m_we, m_addr, m_wdata, m_funct3,
           if_stall, mem_stall
  );

  modport master (
    output i_req, i_addr, i_abort, d_req, d_we, d_addr, d_wdata, d_funct3, m_rdata,
    input  i_done, i_rdata, d_done, d_rdata, m_en, m_we, m_addr, m_wdata, m_funct3,
           if_stall, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction
// fetch and the MEM stage. Data accesses win, but a burst counter forces
// a fetch grant after MAX_D_BURST consecutive data grants with fetch waiting.
module mem_port_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
  // Fetches are always whole-word reads.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              kill_q, kill_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              i_done, d_done, m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_funct3;
  logic              grant_d, grant_i;

  // State, counters, kill flag and read-data hold registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      burst_q   <= '0;
      kill_q    <= 1'b0;
      store_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      burst_q   <= burst_d;
      kill_q    <= kill_d;
      store_q   <= store_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Grant decision, memory command, done pulses and next-state logic.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    lat_d     = lat_q;
    burst_d   = bus.i_req ? burst_q : '0;
    kill_d    = kill_q;
    store_d   = store_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done    = 1'b0;
    d_done    = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_funct3  = '0;
    grant_d   = 1'b0;
    grant_i   = 1'b0;

    // Outputs stay quiet while reset is held; the registers clear at the edge.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.d_req && (burst_q < BURST_MAX)) grant_d = 1'b1;
          else if (bus.i_req && !bus.i_abort)     grant_i = 1'b1;
          else if (bus.d_req)                     grant_d = 1'b1;

          if (grant_d) begin
            m_en     = 1'b1;
            m_we     = bus.d_we;
            m_addr   = bus.d_addr;
            m_wdata  = bus.d_wdata;
            m_funct3 = bus.d_funct3;
            lat_d    = 4'(MEM_LAT);
            store_d  = bus.d_we;
            state_d  = WAIT_D;
            if (bus.i_req && (burst_q != BURST_MAX)) burst_d = burst_q + BW'(1);
          end else if (grant_i) begin
            m_en     = 1'b1;
            m_addr   = bus.i_addr;
            m_funct3 = FETCH_FUNCT3;
            lat_d    = 4'(MEM_LAT);
            kill_d   = 1'b0;
            burst_d  = '0;
            state_d  = WAIT_I;
          end
        end

        WAIT_I: begin
          lat_d = lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            // A flush at any point of the fetch discards its data.
            if (!kill_q && !bus.i_abort) begin
              i_done    = 1'b1;
              i_rdata_d = bus.m_rdata;
            end
            kill_d  = 1'b0;
            state_d = IDLE;
          end else if (bus.i_abort) begin
            kill_d = 1'b1;
          end
        end

        WAIT_D: begin
          lat_d = lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            d_done = 1'b1;
            if (!store_q) d_rdata_d = bus.m_rdata;
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.i_done    = i_done;
  assign bus.d_done    = d_done;
  assign bus.i_rdata   = i_rdata_d;
  assign bus.d_rdata   = d_rdata_d;
  assign bus.m_en      = m_en;
  assign bus.m_we      = m_we;
  assign bus.m_addr    = m_addr;
  assign bus.m_wdata   = m_wdata;
  assign bus.m_funct3  = m_funct3;
  assign bus.if_stall  = bus.i_req & ~i_done & ~bus.i_abort;
  assign bus.mem_stall = bus.d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, MAX_D_BURST=4):
// a per-cycle vector table for the basic flows plus directed sequences
// for burst fairness, fetch abort and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .MAX_D_BURST(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: word array, read data valid two cycles after issue.
  logic [31:0] mem [0:127];
  logic [31:0] pipe0, pipe1;
  initial begin
    for (int w = 0; w < 128; w++) mem[w] = 32'hC0DE_0000 | 32'(w);
    mem[4] = 32'h0050_0093;
    pipe0 = JUNK;
    pipe1 = JUNK;
  end
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        mem[bus.m_addr[8:2]] <= bus.m_wdata;
        pipe0 <= JUNK;
      end else begin
        pipe0 <= mem[bus.m_addr[8:2]];
      end
    end else begin
      pipe0 <= JUNK;
    end
    pipe1 <= pipe0;
  end
  assign bus.m_rdata = pipe1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        i_req;
    logic [8:0]  i_addr;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_f3;
    logic        e_m_en;
    logic        e_m_we;
    logic [8:0]  e_m_addr;
    logic [31:0] e_m_wdata;
    logic [2:0]  e_m_f3;
    logic        e_i_done;
    logic        e_d_done;
    logic        e_if_stall;
    logic        e_mem_stall;
    logic [31:0] e_i_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t tbl [19];

  task automatic drive_idle();
    bus.i_req = 0; bus.i_addr = '0; bus.i_abort = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] P = 32'h0050_0093;
  localparam logic [31:0] L = 32'hC0DE_0020;
  localparam logic [31:0] F = 32'hC0DE_0005;
  localparam logic [31:0] B = 32'hDEAD_BEEF;

  initial begin
    // i_req i_addr d_req d_we d_addr d_wdata d_f3 | m_en m_we m_addr m_wdata m_f3 i_done d_done if_st mem_st i_rdata d_rdata
    tbl[0]  = '{0, 9'h000, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 9'h010, 0, 0, 9'h000, 0, 3'd0,  1, 0, 9'h010, 0, 3'd2, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 9'h010, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 9'h010, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 1, 0, 0, 0, P, 0};
    tbl[4]  = '{0, 9'h000, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 0, 0, P, 0};
    tbl[5]  = '{1, 9'h014, 1, 0, 9'h080, 0, 3'd2,  1, 0, 9'h080, 0, 3'd2, 0, 0, 1, 1, P, 0};
    tbl[6]  = '{1, 9'h014, 1, 0, 9'h080, 0, 3'd2,  0, 0, 9'h000, 0, 3'd0, 0, 0, 1, 1, P, 0};
    tbl[7]  = '{1, 9'h014, 1, 0, 9'h080, 0, 3'd2,  0, 0, 9'h000, 0, 3'd0, 0, 1, 1, 0, P, L};
    tbl[8]  = '{1, 9'h014, 0, 0, 9'h000, 0, 3'd0,  1, 0, 9'h014, 0, 3'd2, 0, 0, 1, 0, P, L};
    tbl[9]  = '{1, 9'h014, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 1, 0, P, L};
    tbl[10] = '{1, 9'h014, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 1, 0, 0, 0, F, L};
    tbl[11] = '{0, 9'h000, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 0, 0, F, L};
    tbl[12] = '{0, 9'h000, 1, 1, 9'h040, B, 3'd2,  1, 1, 9'h040, B, 3'd2, 0, 0, 0, 1, F, L};
    tbl[13] = '{0, 9'h000, 1, 1, 9'h040, B, 3'd2,  0, 0, 9'h000, 0, 3'd0, 0, 0, 0, 1, F, L};
    tbl[14] = '{0, 9'h000, 1, 1, 9'h040, B, 3'd2,  0, 0, 9'h000, 0, 3'd0, 0, 1, 0, 0, F, L};
    tbl[15] = '{1, 9'h040, 0, 0, 9'h000, 0, 3'd0,  1, 0, 9'h040, 0, 3'd2, 0, 0, 1, 0, F, L};
    tbl[16] = '{1, 9'h040, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 1, 0, F, L};
    tbl[17] = '{1, 9'h040, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 1, 0, 0, 0, B, L};
    tbl[18] = '{0, 9'h000, 0, 0, 9'h000, 0, 3'd0,  0, 0, 9'h000, 0, 3'd0, 0, 0, 0, 0, B, L};

    // ---- reset state ----
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_m_en",     32'(bus.m_en), 0);
    check("rst_m_we",     32'(bus.m_we), 0);
    check("rst_m_addr",   32'(bus.m_addr), 0);
    check("rst_i_done",   32'(bus.i_done), 0);
    check("rst_d_done",   32'(bus.d_done), 0);
    check("rst_i_rdata",  bus.i_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata, 0);
    check("rst_if_stall", 32'(bus.if_stall), 0);
    next_cycle();
    reset = 1'b0;

    // ---- table: fetch, D-over-I priority, store then fetch-back ----
    for (int v = 0; v < 19; v++) begin
      bus.i_req = tbl[v].i_req;   bus.i_addr  = tbl[v].i_addr;  bus.i_abort  = 1'b0;
      bus.d_req = tbl[v].d_req;   bus.d_we    = tbl[v].d_we;    bus.d_addr   = tbl[v].d_addr;
      bus.d_wdata = tbl[v].d_wdata; bus.d_funct3 = tbl[v].d_f3;
      @(negedge clk);
      check($sformatf("v%0d_m_en", v),      32'(bus.m_en),      32'(tbl[v].e_m_en));
      check($sformatf("v%0d_m_we", v),      32'(bus.m_we),      32'(tbl[v].e_m_we));
      check($sformatf("v%0d_m_addr", v),    32'(bus.m_addr),    32'(tbl[v].e_m_addr));
      check($sformatf("v%0d_m_wdata", v),   bus.m_wdata,        tbl[v].e_m_wdata);
      check($sformatf("v%0d_m_funct3", v),  32'(bus.m_funct3),  32'(tbl[v].e_m_f3));
      check($sformatf("v%0d_i_done", v),    32'(bus.i_done),    32'(tbl[v].e_i_done));
      check($sformatf("v%0d_d_done", v),    32'(bus.d_done),    32'(tbl[v].e_d_done));
      check($sformatf("v%0d_if_stall", v),  32'(bus.if_stall),  32'(tbl[v].e_if_stall));
      check($sformatf("v%0d_mem_stall", v), 32'(bus.mem_stall), 32'(tbl[v].e_mem_stall));
      check($sformatf("v%0d_i_rdata", v),   bus.i_rdata,        tbl[v].e_i_rdata);
      check($sformatf("v%0d_d_rdata", v),   bus.d_rdata,        tbl[v].e_d_rdata);
      next_cycle();
    end

    // ---- burst guard: both sides requesting continuously ----
    begin
      int  dcnt = 0;
      int  igrants = 0;
      bit  finished = 0;
      bit  chk_burst = 0;
      bus.i_req = 1; bus.i_addr = 9'h018;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h084; bus.d_wdata = '0; bus.d_funct3 = 3'd2;
      for (int c = 0; c < 80 && !finished; c++) begin
        @(negedge clk);
        if (chk_burst) begin
          check("burst_cleared", 32'(dut.burst_q), 0);
          chk_burst = 0;
        end
        if (bus.m_en) begin
          if (bus.m_addr == 9'h084) dcnt++;
          else begin
            igrants++;
            check($sformatf("burst_d_grants_%0d", igrants), 32'(dcnt), 4);
            check("burst_i_addr", 32'(bus.m_addr), 32'h018);
            dcnt = 0;
            chk_burst = 1;
            if (igrants == 2) finished = 1;
          end
        end
      end
      check("burst_budget", 32'(finished), 1);
      next_cycle();
      bus.d_req = 0;
      finished = 0;
      for (int c = 0; c < 10 && !finished; c++) begin
        @(negedge clk);
        if (bus.i_done) begin
          finished = 1;
          check("burst_i_rdata", bus.i_rdata, 32'hC0DE_0006);
        end
      end
      check("burst_i_done_seen", 32'(finished), 1);
      next_cycle();
      bus.i_req = 0;
      @(negedge clk);
      next_cycle();
    end

    // ---- fetch abort in the first wait cycle ----
    bus.i_req = 1; bus.i_addr = 9'h010;
    @(negedge clk);
    check("abort_issue", 32'(bus.m_en), 1);
    next_cycle();
    bus.i_abort = 1;
    @(negedge clk);
    check("abort_w1_i_done", 32'(bus.i_done), 0);
    check("abort_w1_if_stall", 32'(bus.if_stall), 0);
    next_cycle();
    bus.i_abort = 0; bus.i_req = 0;
    @(negedge clk);
    check("abort_w2_i_done", 32'(bus.i_done), 0);
    check("abort_i_rdata_kept", bus.i_rdata, 32'hC0DE_0006);
    next_cycle();
    bus.i_req = 1; bus.i_addr = 9'h020;
    @(negedge clk);
    check("abort_reissue_m_en", 32'(bus.m_en), 1);
    check("abort_reissue_addr", 32'(bus.m_addr), 32'h020);
    next_cycle();
    @(negedge clk);
    check("abort_reissue_wait", 32'(bus.i_done), 0);
    next_cycle();
    @(negedge clk);
    check("abort_reissue_done", 32'(bus.i_done), 1);
    check("abort_reissue_rdata", bus.i_rdata, 32'hC0DE_0008);
    next_cycle();
    bus.i_req = 0;
    @(negedge clk);
    next_cycle();

    // ---- reset in the cycle after a data grant ----
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h088; bus.d_funct3 = 3'd2;
    @(negedge clk);
    check("rstmid_issue", 32'(bus.m_en), 1);
    check("rstmid_addr", 32'(bus.m_addr), 32'h088);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_d_done_r", 32'(bus.d_done), 0);
    next_cycle();
    reset = 1'b0; bus.d_req = 0;
    @(negedge clk);
    check("rstmid_state_idle", 32'(dut.state_q), 0);
    check("rstmid_d_done_a", 32'(bus.d_done), 0);
    check("rstmid_m_en", 32'(bus.m_en), 0);
    check("rstmid_d_rdata", bus.d_rdata, 0);
    next_cycle();
    bus.i_req = 1; bus.i_addr = 9'h010;
    @(negedge clk);
    check("rstmid_new_issue", 32'(bus.m_en), 1);
    check("rstmid_new_addr", 32'(bus.m_addr), 32'h010);
    check("rstmid_d_done_b", 32'(bus.d_done), 0);
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("rstmid_new_done", 32'(bus.i_done), 1);
    check("rstmid_new_rdata", bus.i_rdata, P);
    next_cycle();
    bus.i_req = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
